// File: rtl/bf_r2_sdf_stage.sv
// Radix-2 single-delay-feedback butterfly stage, LANES complex lanes per beat.
// Sums leave one cycle after each second-half beat; differences drain afterwards.
module bf_r2_sdf_stage #(
    parameter int I_WIDTH = 13,
    parameter int LANES = 16,
    parameter int DELAY = 4,
    localparam int O_WIDTH = I_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_valid,
    input  logic [1:0]                i_mode,
    input  logic signed [I_WIDTH-1:0] din_re [0:LANES-1],
    input  logic signed [I_WIDTH-1:0] din_im [0:LANES-1],
    output logic signed [O_WIDTH-1:0] dout_re [0:LANES-1],
    output logic signed [O_WIDTH-1:0] dout_im [0:LANES-1],
    output logic                      o_valid,
    output logic                      o_sel,
    output logic                      o_frame_start,
    output logic                      o_sat,
    output logic                      o_busy
);

    localparam int BW = $clog2(2 * DELAY);
    localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [BW-1:0] B_HALF = BW'(DELAY);
    localparam logic [BW-1:0] B_LAST = BW'(2 * DELAY - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DELAY - 1);

    logic [BW-1:0] b;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] slot;
    logic          drain_act;
    logic          phase_b;
    logic [1:0]    mode_q;
    logic [1:0]    dmode;

    logic signed [I_WIDTH-1:0] st_re [DELAY][LANES];
    logic signed [I_WIDTH-1:0] st_im [DELAY][LANES];
    logic signed [O_WIDTH-1:0] df_re [DELAY][LANES];
    logic signed [O_WIDTH-1:0] df_im [DELAY][LANES];

    logic signed [O_WIDTH-1:0] d_re  [LANES];
    logic signed [O_WIDTH-1:0] d_im  [LANES];
    logic signed [O_WIDTH-1:0] sm_re [LANES];
    logic signed [O_WIDTH-1:0] sm_im [LANES];
    logic signed [O_WIDTH-1:0] dm_re [LANES];
    logic signed [O_WIDTH-1:0] dm_im [LANES];
    logic                      sat_s;
    logic                      sat_d;

    // Returns {clipped, mapped value}; overflow of I_WIDTH shows as top two bits differing.
    function automatic logic [O_WIDTH:0] fmap(input logic [O_WIDTH-1:0] v,
                                              input logic [1:0] m);
        logic [O_WIDTH:0] r;
        logic [O_WIDTH:0] t;
        r = {1'b0, v};
        t = {v[O_WIDTH-1], v} + (O_WIDTH+1)'(1);
        case (m)
            2'd1: if (v[O_WIDTH-1] != v[O_WIDTH-2])
                      r = {1'b1, v[O_WIDTH-1], v[O_WIDTH-1],
                           {(I_WIDTH-1){~v[O_WIDTH-1]}}};
            2'd2: r = {1'b0, t[O_WIDTH:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    assign phase_b = (b >= B_HALF);
    assign slot    = phase_b ? DW'(b - B_HALF) : DW'(b);
    assign o_busy  = (b != '0) || drain_act || (o_valid && o_sel);

    always_comb begin
        logic f;
        logic signed [O_WIDTH-1:0] s;
        f = 1'b0;
        s = '0;
        sat_s = 1'b0;
        sat_d = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            s = {st_re[slot][l][I_WIDTH-1], st_re[slot][l]}
              + {din_re[l][I_WIDTH-1], din_re[l]};
            {f, sm_re[l]} = fmap(s, mode_q);
            sat_s = sat_s | f;
            s = {st_im[slot][l][I_WIDTH-1], st_im[slot][l]}
              + {din_im[l][I_WIDTH-1], din_im[l]};
            {f, sm_im[l]} = fmap(s, mode_q);
            sat_s = sat_s | f;
            d_re[l] = {st_re[slot][l][I_WIDTH-1], st_re[slot][l]}
                    - {din_re[l][I_WIDTH-1], din_re[l]};
            d_im[l] = {st_im[slot][l][I_WIDTH-1], st_im[slot][l]}
                    - {din_im[l][I_WIDTH-1], din_im[l]};
            {f, dm_re[l]} = fmap(df_re[dcnt][l], dmode);
            sat_d = sat_d | f;
            {f, dm_im[l]} = fmap(df_im[dcnt][l], dmode);
            sat_d = sat_d | f;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b             <= '0;
            dcnt          <= '0;
            drain_act     <= 1'b0;
            mode_q        <= 2'd0;
            dmode         <= 2'd0;
            o_valid       <= 1'b0;
            o_sel         <= 1'b0;
            o_frame_start <= 1'b0;
            o_sat         <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                dout_re[l] <= '0;
                dout_im[l] <= '0;
            end
            for (int k = 0; k < DELAY; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    st_re[k][l] <= '0;
                    st_im[k][l] <= '0;
                    df_re[k][l] <= '0;
                    df_im[k][l] <= '0;
                end
            end
        end else begin
            o_valid       <= 1'b0;
            o_sel         <= 1'b0;
            o_frame_start <= 1'b0;
            o_sat         <= 1'b0;
            if (i_valid) begin
                b <= (b == B_LAST) ? '0 : b + 1'b1;
                if (b == '0)
                    mode_q <= (i_mode == 2'd3) ? 2'd0 : i_mode;
                if (!phase_b) begin
                    for (int l = 0; l < LANES; l++) begin
                        st_re[slot][l] <= din_re[l];
                        st_im[slot][l] <= din_im[l];
                    end
                end else begin
                    for (int l = 0; l < LANES; l++) begin
                        df_re[slot][l] <= d_re[l];
                        df_im[slot][l] <= d_im[l];
                        dout_re[l]     <= sm_re[l];
                        dout_im[l]     <= sm_im[l];
                    end
                    o_valid       <= 1'b1;
                    o_frame_start <= (b == B_HALF);
                    o_sat         <= sat_s;
                end
                if (b == B_LAST) begin
                    drain_act <= 1'b1;
                    dcnt      <= '0;
                    dmode     <= mode_q;
                end
            end
            // A drain never overlaps a sum beat; the guard only fixes priority.
            if (drain_act && !(i_valid && phase_b)) begin
                for (int l = 0; l < LANES; l++) begin
                    dout_re[l] <= dm_re[l];
                    dout_im[l] <= dm_im[l];
                end
                o_valid <= 1'b1;
                o_sel   <= 1'b1;
                o_sat   <= sat_d;
                dcnt    <= dcnt + 1'b1;
                if (dcnt == D_LAST)
                    drain_act <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bf_r2_sdf_stage.sv
// Scoreboard bench for bf_r2_sdf_stage with a frame-level arithmetic model.
module tb_bf_r2_sdf_stage;

    localparam int IW = 13;
    localparam int L = 16;
    localparam int D = 4;
    localparam int OW = IW + 1;
    localparam int MAXI = (1 << (IW - 1)) - 1;
    localparam int MINI = -(1 << (IW - 1));

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic i_valid = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic signed [IW-1:0] din_re [0:L-1];
    logic signed [IW-1:0] din_im [0:L-1];
    logic signed [OW-1:0] dout_re [0:L-1];
    logic signed [OW-1:0] dout_im [0:L-1];
    logic o_valid, o_sel, o_frame_start, o_sat, o_busy;

    always #5 clk = ~clk;

    bf_r2_sdf_stage #(.I_WIDTH(IW), .LANES(L), .DELAY(D)) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_mode(i_mode),
        .din_re(din_re), .din_im(din_im),
        .dout_re(dout_re), .dout_im(dout_im),
        .o_valid(o_valid), .o_sel(o_sel), .o_frame_start(o_frame_start),
        .o_sat(o_sat), .o_busy(o_busy)
    );

    typedef struct {
        int cyc;
        bit sel;
        bit fs;
        bit sat;
        int re [L];
        int im [L];
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_re [L];
    int cur_im [L];
    int mb = 0;
    int mmode = 0;
    int st_re [D][L];
    int st_im [D][L];
    int df_re [D][L];
    int df_im [D][L];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mapv(input int v, input int m);
        if (m == 1) return (v > MAXI) ? MAXI : (v < MINI) ? MINI : v;
        if (m == 2) return (v + 1) >>> 1;
        return v;
    endfunction

    function automatic bit clipped(input int v, input int m);
        return (m == 1) && (v > MAXI || v < MINI);
    endfunction

    task automatic model_beat(input int m);
        exp_t e;
        int k, s;
        if (mb == 0) mmode = (m == 3) ? 0 : m;
        if (mb < D) begin
            for (int l = 0; l < L; l++) begin
                st_re[mb][l] = cur_re[l];
                st_im[mb][l] = cur_im[l];
            end
        end else begin
            k = mb - D;
            e.cyc = cyc + 1;
            e.sel = 1'b0;
            e.fs = (mb == D);
            e.sat = 1'b0;
            for (int l = 0; l < L; l++) begin
                s = st_re[k][l] + cur_re[l];
                e.re[l] = mapv(s, mmode);
                if (clipped(s, mmode)) e.sat = 1'b1;
                s = st_im[k][l] + cur_im[l];
                e.im[l] = mapv(s, mmode);
                if (clipped(s, mmode)) e.sat = 1'b1;
                df_re[k][l] = st_re[k][l] - cur_re[l];
                df_im[k][l] = st_im[k][l] - cur_im[l];
            end
            q.push_back(e);
            if (mb == 2 * D - 1) begin
                for (int j = 0; j < D; j++) begin
                    e.cyc = cyc + 2 + j;
                    e.sel = 1'b1;
                    e.fs = 1'b0;
                    e.sat = 1'b0;
                    for (int l = 0; l < L; l++) begin
                        e.re[l] = mapv(df_re[j][l], mmode);
                        e.im[l] = mapv(df_im[j][l], mmode);
                        if (clipped(df_re[j][l], mmode)) e.sat = 1'b1;
                        if (clipped(df_im[j][l], mmode)) e.sat = 1'b1;
                    end
                    q.push_back(e);
                end
            end
        end
        mb = (mb + 1) % (2 * D);
    endtask

    task automatic step(input bit v, input int m);
        @(posedge clk);
        #1;
        i_valid = v;
        i_mode = 2'(m);
        for (int l = 0; l < L; l++) begin
            din_re[l] = IW'(cur_re[l]);
            din_im[l] = IW'(cur_im[l]);
        end
        if (v) model_beat(m);
    endtask

    task automatic set_all(input int re, input int im);
        for (int l = 0; l < L; l++) begin
            cur_re[l] = re;
            cur_im[l] = im;
        end
    endtask

    task automatic set_rand();
        for (int l = 0; l < L; l++) begin
            cur_re[l] = int'($urandom_range(0, 8191)) - 4096;
            cur_im[l] = int'($urandom_range(0, 8191)) - 4096;
        end
    endtask

    task automatic set_re_rand_im(input int re);
        set_rand();
        for (int l = 0; l < L; l++) cur_re[l] = re;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int bad;
        if (rstn && o_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: o_valid=1 with nothing pending (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("o_sel", int'(o_sel), int'(e.sel));
                chk("o_frame_start", int'(o_frame_start), int'(e.fs));
                chk("o_sat", int'(o_sat), int'(e.sat));
                bad = -1;
                for (int l = 0; l < L; l++)
                    if (int'(dout_re[l]) != e.re[l] || int'(dout_im[l]) != e.im[l]) bad = l;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL dout lane %0d: got (%0d,%0d) expected (%0d,%0d) sel=%0d (cycle %0d)",
                             bad, dout_re[bad], dout_im[bad], e.re[bad], e.im[bad], e.sel, cyc);
                end
            end
        end
    end

    initial begin
        int t0, beats;
        bit v;
        set_all(0, 0);
        for (int l = 0; l < L; l++) begin
            din_re[l] = '0;
            din_im[l] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_busy", int'(o_busy), 0);
        chk("rst_o_sel", int'(o_sel), 0);
        chk("rst_o_frame_start", int'(o_frame_start), 0);
        chk("rst_o_sat", int'(o_sat), 0);
        chk("rst_dout_re0", int'(dout_re[0]), 0);
        chk("rst_dout_im_last", int'(dout_im[L-1]), 0);
        rstn = 1'b1;
        repeat (5) step(0, 0);
        chk("idle_o_valid", int'(o_valid), 0);

        // contiguous frame, mode 0
        t0 = 0;
        for (int i = 0; i < 2 * D; i++) begin
            set_all(i + 1, 0);
            step(1, 0);
            if (i == 0) t0 = cyc;
        end
        set_all(0, 0);
        repeat (5) step(0, 0);
        chk("busy_last_diff", int'(o_busy), 1);
        step(0, 0);
        chk("busy_fall_cycle", cyc - t0, 13);
        chk("busy_fall", int'(o_busy), 0);

        // saturation corners, mode 1
        set_all(MAXI, MAXI); step(1, 1);
        set_all(MINI, MINI); step(1, 0);
        set_rand(); step(1, 0);
        set_rand(); step(1, 0);
        set_all(MAXI, MAXI); step(1, 0);
        set_all(MINI, MINI); step(1, 0);
        set_rand(); step(1, 0);
        set_rand(); step(1, 0);
        set_all(0, 0);
        repeat (D + 2) step(0, 0);

        // rounding corners, mode 2
        set_re_rand_im(3); step(1, 2);
        set_re_rand_im(-3); step(1, 2);
        set_re_rand_im(MINI); step(1, 2);
        set_rand(); step(1, 2);
        set_re_rand_im(2); step(1, 2);
        set_re_rand_im(0); step(1, 2);
        set_re_rand_im(MINI); step(1, 2);
        set_rand(); step(1, 2);
        repeat (D + 2) step(0, 0);

        // stalls after beats 1 and 5, mode changes mid-frame
        for (int i = 0; i < 2 * D; i++) begin
            set_re_rand_im(i + 1);
            step(1, (i == 0) ? 0 : 2);
            if (i == 1 || i == 5) repeat (3) step(0, 1);
        end
        repeat (D + 2) step(0, 0);

        // back-to-back random frames, phase A overlapping drain
        beats = 0;
        for (int it = 0; it < 400 && beats < 6 * D; it++) begin
            v = ($urandom_range(0, 3) != 0) || (it >= 200);
            set_rand();
            step(v, int'($urandom_range(0, 3)));
            if (v) beats++;
        end
        repeat (D + 2) step(0, 0);

        // reset during the second drain beat
        for (int i = 0; i < 2 * D; i++) begin
            set_rand();
            step(1, int'($urandom_range(0, 2)));
        end
        step(0, 0);
        step(0, 0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        q.delete();
        mb = 0;
        #1;
        chk("midrst_o_valid", int'(o_valid), 0);
        chk("midrst_dout_re0", int'(dout_re[0]), 0);
        chk("midrst_o_busy", int'(o_busy), 0);
        chk("midrst_o_sel", int'(o_sel), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 2 * D; i++) begin
            set_rand();
            step(1, int'($urandom_range(0, 3)));
        end
        repeat (D + 3) step(0, 0);

        chk("pending_left", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf_r2_sdf_stage.md
Name: bf_r2_sdf_stage

Overview:
- Parametrised radix-2 single-delay-feedback butterfly stage for the parallel-lane FFT datapath. Processes LANES complex samples per beat.
- Frame length is 2*DELAY beats. The first DELAY beats are stored. The second DELAY beats are combined with the stored beats: the sum is emitted immediately and the difference is buffered, then drained autonomously.
- Adds over the fixed-depth stage: generic delay depth, width and lane count; stall-tolerant counting; per-frame selectable output mode (full growth / saturate / round-halve); saturation flag.
- Sits between input reorder and the twiddle-multiply stage.

Parameters:
- I_WIDTH, 13: signed input sample width (re and im each).
- LANES, 16: parallel complex lanes per beat.
- DELAY, 4: beats per half-frame; any value >= 1.
- O_WIDTH: derived, I_WIDTH+1; output sample width, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  beat accepted this cycle.
- i_mode  in  2  output mode, sampled on beat 0 of each frame: 0 full, 1 saturate, 2 round-halve, 3 treated as 0.
- din_re  in  signed [I_WIDTH-1:0] x [0:LANES-1]  real input.
- din_im  in  signed [I_WIDTH-1:0] x [0:LANES-1]  imaginary input.
- dout_re  out  signed [O_WIDTH-1:0] x [0:LANES-1]  real output.
- dout_im  out  signed [O_WIDTH-1:0] x [0:LANES-1]  imaginary output.
- o_valid  out  1  output beat valid.
- o_sel  out  1  0 = sum beat, 1 = difference beat.
- o_frame_start  out  1  high on the first sum beat of a frame.
- o_sat  out  1  any lane or component clipped on this output beat (mode 1 only).
- o_busy  out  1  frame in progress or drain pending.

Behaviour:
- Reset: all outputs 0. Beat counter, drain counter, stored mode and both buffers are cleared. Asserting reset mid-frame or mid-drain discards all state; the next valid beat is beat 0.
- Beat counter b (0..2*DELAY-1) advances only on i_valid and wraps to 0 after 2*DELAY-1. While i_valid is low, b holds (stall); nothing is written and no sum is output.
- Phase A (b < DELAY): the input is written to store slot b. No output is produced.
- Phase B (b >= DELAY), per lane and component: a = store[b-DELAY], x = input. Compute s = a+x and d = a-x at O_WIDTH. The mode-mapped s is registered to dout with o_valid=1, o_sel=0, latency 1 cycle. o_frame_start=1 when b==DELAY. d is written raw to diff slot b-DELAY.
- Drain: the cycle after the beat b=2*DELAY-1 is accepted, drain starts. Diff slots 0..DELAY-1 are emitted one per cycle on consecutive cycles, independent of i_valid, with o_valid=1, o_sel=1, mode-mapped. If the last phase-B beat is accepted at cycle T, the last sum appears at T+1 and the diffs at T+2..T+DELAY+1.
- Drain cannot collide with the next frame: the next phase B starts at least DELAY accepted beats later. Phase-A input is accepted concurrently with drain.
- Mode mapping for a value v at O_WIDTH bits:
  - 0: v unchanged.
  - 1: clip to [-2^(I_WIDTH-1), 2^(I_WIDTH-1)-1], sign-extended to O_WIDTH. o_sat=1 if any clip occurred on that beat.
  - 2: (v+1)>>>1, arithmetic shift; the result always fits I_WIDTH and is sign-extended.
- The mode sampled at beat 0 applies to that frame's sums and diffs, even if i_mode changes mid-frame.
- o_busy = (b != 0) or drain active.
- When o_valid=0, dout holds its last value.

Test Plan:
- Reset: hold rstn=0 -> all outputs 0 and o_busy=0. Release, drive idle 5 cycles -> o_valid stays 0.
- Contiguous frame, mode 0, DELAY=4, all lanes re=1..8 and im=0, beats at cycles 0..7 -> sums 6,8,10,12 at cycles 5..8 (o_frame_start at 5). Diffs -4,-4,-4,-4 at cycles 9..12 with o_sel=1. o_busy falls at cycle 13.
- Mode 1: a=4095, x=4095 -> sum 4095 with o_sat=1, diff 0 with o_sat=0. a=x=-4096 -> sum -4096 with o_sat=1.
- Mode 2 rounding: (a,x)=(3,2) -> sum 3, diff 1. (-3,0) -> sum -1, diff -1. (-4096,-4096) -> sum -4096.
- Stall: i_valid low for 3 cycles after beat 1 and after beat 5 -> same values as the contiguous case, sums delayed accordingly. Diffs still on 4 consecutive cycles after the last sum. Change i_mode mid-frame -> no effect on that frame.
- Back-to-back frames with new phase-A beats during drain -> frame 2 results correct. Reset asserted at the second drain beat -> outputs 0 immediately, and a following fresh frame is processed correctly from beat 0.
